dmem_access: RTL and testbench
==============================

Name: dmem_access

Overview:
- Data-memory responder for the control decoder's memory command set: memread, memwrite, storeops and the load funct3.
- Converts each load/store command into transactions on a word-wide, ack-based data memory with no byte enables.
- Sub-word stores use read-modify-write; loads are extracted and sign- or zero-extended.
- Holds the core pipeline through req_ready until the response has been delivered.

Parameters:
- ADDR_W, 32, byte address width; the memory word address is ADDR_W-2 bits.
- TIMEOUT, 16, maximum cycles to wait for mem_ack per bus phase before aborting (≥1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  FSM is in IDLE and can accept a command
- memread  in  1  load command
- memwrite  in  1  store command
- storeops  in  2  0 none, 1 byte, 2 half, 3 word
- load_funct  in  3  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-aligned
- rdata  out  32  extended load result
- resp_valid  out  1  one-cycle completion pulse
- err  out  1  qualifies resp_valid: misaligned, illegal or timed out
- mem_req  out  1  bus request
- mem_we  out  1  1 write, 0 read
- mem_addr  out  ADDR_W-2  word address, equal to addr[ADDR_W-1:2]
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid when mem_ack is high
- mem_ack  in  1  transaction complete, one cycle

Behaviour:
- Reset: all outputs 0 except req_ready=1. FSM goes to IDLE, timeout counter is cleared, latched command is cleared. Reset during any state drops mem_req on the next edge; no response is issued.

- State IDLE:
  - Accept a command when req_valid and (memread or memwrite). Latch addr, wdata, storeops, load_funct.
  - req_valid with neither memread nor memwrite set is ignored.

- Illegal or misaligned commands (checked at accept):
  - memread and memwrite both set.
  - memwrite with storeops=0.
  - load_funct in {3,6,7}.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Result: go to RESP with err=1 and rdata=0. No bus activity occurs.

- Routing after accept:
  - Load → RD.
  - Word store → WR, with mem_wdata=wdata.
  - Byte or half store → RD, then MERGE.

- State RD: mem_req=1, mem_we=0, held until mem_ack.
  - Load: on ack, register the extracted data, then go to RESP.
  - Sub-word store: on ack, go to MERGE.
- State MERGE (1 cycle): build the write word from the read word.
  - Byte: lane addr[1:0] is replaced with wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} are replaced with wdata[15:0].
  - Then go to WR.
- State WR: mem_req=1, mem_we=1, mem_wdata held stable until mem_ack, then go to RESP.
- State RESP: resp_valid=1 for exactly one cycle, then IDLE. rdata is meaningful only for loads without error; it is 0 for stores.

- Load extraction: the byte or half lane is selected by addr[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through unchanged.

- Bus timing:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stable while mem_req=1.
  - mem_ack is sampled only while mem_req=1; a stray ack at any other time is ignored.
  - mem_ack in the first mem_req cycle is legal.

- Timeout:
  - The counter clears on entry to RD or WR and increments each cycle without ack.
  - When TIMEOUT cycles pass without ack, drop mem_req and go to RESP with err=1.
  - A read-modify-write aborted in RD never issues its write.

- Latency with ack in the first request cycle, counting the accept edge as cycle 0:
  - Load / word store: resp_valid at cycle 2.
  - Sub-word store: resp_valid at cycle 4.
  - Error at accept: resp_valid at cycle 1.

- req_ready=0 in every state except IDLE. Inputs are ignored while busy.

Test Plan:
- LB addr=0x103, mem_rdata=0x80FF_1234 with ack on the first cycle → mem_addr=0x40; rdata=0xFFFF_FF80, err=0, resp_valid at cycle 2.
- LHU addr=0x102, mem_rdata=0x8001_0000 → rdata=0x0000_8001. LH on the same data → rdata=0xFFFF_8001.
- SB addr=0x201, wdata=0xAB, read word 0x1122_3344 → one read, then a write with mem_wdata=0x1122_AB44, mem_we=1; resp_valid at cycle 4.
- SW addr=0x8, wdata=0xDEAD_BEEF, ack delayed 3 cycles → no read phase; mem_req held 4 cycles with stable data; resp_valid 1 cycle after ack, err=0.
- Misaligned LW addr=0x6, then SH addr=0x5, then memread=memwrite=1 → each gives resp_valid with err=1 at cycle 1; mem_req never asserts.
- TIMEOUT=4, SH with no ack → mem_req high 4 cycles, err=1, no write issued. Separately, rst asserted mid-WR → mem_req=0 and req_ready=1 on the next cycle, with no resp_valid.

Source files
------------

// File: rtl/dmem_access.sv
// Data-memory responder: turns load/store commands into word-wide, ack-based
// bus transactions. Sub-word stores use read-modify-write. Loads are extracted
// and sign- or zero-extended. Each bus phase is bounded by a timeout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready, waiting for a command
// S_RD    | bus read in flight (load, or first half of a sub-word store)
// S_MERGE | build the write word from the read word
// S_WR    | bus write in flight
// S_RESP  | one-cycle response pulse
module dmem_access #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        storeops,
  input  logic [2:0]        load_funct,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              resp_valid,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [1:0]         so_q, so_d;
  logic [2:0]         lf_q, lf_d;
  logic               is_load_q, is_load_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdword_q, rdword_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;

  logic               acc_half, acc_word, acc_bad;
  logic [31:0]        load_val, merge_val, lane_mask;

  // Classify the incoming command: access size and illegal/misaligned cases
  always_comb begin
    acc_half = memwrite ? (storeops == 2'd2) : (load_funct[1:0] == 2'd1);
    acc_word = memwrite ? (storeops == 2'd3) : (load_funct[1:0] == 2'd2);
    acc_bad  = (memread && memwrite)
            || (memwrite && storeops == 2'd0)
            || (memread && (load_funct == 3'd3 || load_funct == 3'd6 || load_funct == 3'd7))
            || (acc_half && addr[0])
            || (acc_word && addr[1:0] != 2'b00);
  end

  // Load lane extraction from the bus word, with sign/zero extension
  always_comb begin
    case (lf_q)
      3'd0:    load_val = {{24{mem_rdata[{addr_q[1:0], 3'b000} + 7]}},
                           mem_rdata[{addr_q[1:0], 3'b000} +: 8]};
      3'd1:    load_val = {{16{mem_rdata[{addr_q[1], 4'b0000} + 15]}},
                           mem_rdata[{addr_q[1], 4'b0000} +: 16]};
      3'd4:    load_val = {24'd0, mem_rdata[{addr_q[1:0], 3'b000} +: 8]};
      3'd5:    load_val = {16'd0, mem_rdata[{addr_q[1], 4'b0000} +: 16]};
      default: load_val = mem_rdata;
    endcase
  end

  // Sub-word merge: replace the addressed lane(s) of the read word
  always_comb begin
    if (so_q == 2'd1) begin
      lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      merge_val = (rdword_q & ~lane_mask) | ({24'd0, wdata_q[7:0]} << {addr_q[1:0], 3'b000});
    end else begin
      lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      merge_val = (rdword_q & ~lane_mask) | ({16'd0, wdata_q} << {addr_q[1], 4'b0000});
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    so_d        = so_q;
    lf_d        = lf_q;
    is_load_d   = is_load_q;
    cnt_d       = cnt_q;
    rdword_d    = rdword_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && (memread || memwrite)) begin
          addr_d    = addr;
          wdata_d   = wdata[15:0];
          so_d      = storeops;
          lf_d      = load_funct;
          is_load_d = memread && !memwrite;
          cnt_d     = '0;
          rdata_d   = '0;
          err_d     = 1'b0;
          if (acc_bad) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (memread || storeops != 2'd3) begin
            state_d   = S_RD;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end else begin
            state_d     = S_WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = wdata;
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (is_load_q) begin
            rdata_d = load_val;
            state_d = S_RESP;
          end else begin
            rdword_d = mem_rdata;
            state_d  = S_MERGE;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MERGE: begin
        mem_wdata_d = merge_val;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        cnt_d       = '0;
        state_d     = S_WR;
      end
      S_WR: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      so_q        <= '0;
      lf_q        <= '0;
      is_load_q   <= 1'b0;
      cnt_q       <= '0;
      rdword_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      so_q        <= so_d;
      lf_q        <= lf_d;
      is_load_q   <= is_load_d;
      cnt_q       <= cnt_d;
      rdword_q    <= rdword_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign err        = resp_valid && err_q;
  assign rdata      = rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q[ADDR_W-1:2];
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access.sv
// Bench for dmem_access: directed cases followed by random commands, checked
// against a byte-addressed memory model and an ack-delay based latency model.
module tb_dmem_access;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, memread, memwrite;
  logic [1:0]  storeops;
  logic [2:0]  load_funct;
  logic [31:0] addr, wdata, rdata;
  logic        resp_valid, err, mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  dmem_access #(.ADDR_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .memread(memread), .memwrite(memwrite), .storeops(storeops),
    .load_funct(load_funct), .addr(addr), .wdata(wdata), .rdata(rdata),
    .resp_valid(resp_valid), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ref_b   [0:4095];
  logic [31:0] bus_mem [0:1023];

  int          d_rd, d_wr, phase_cnt, rd_hi, wr_hi, n_rd, n_wr;
  bit          no_ack, stray_en;
  logic [29:0] cur_waddr;
  logic        ph_we;
  logic [31:0] ph_wdata, last_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input bit wr, input logic [1:0] so, input logic [2:0] lf);
    if (wr) return (so == 2'd1) ? 1 : (so == 2'd2) ? 2 : 4;
    return (lf[1:0] == 2'd0) ? 1 : (lf[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_illegal(input bit rd, input bit wr, input logic [1:0] so,
                                    input logic [2:0] lf, input logic [31:0] a);
    int sz;
    if (rd && wr) return 1'b1;
    if (wr && so == 2'd0) return 1'b1;
    if (rd && (lf == 3'd3 || lf == 3'd6 || lf == 3'd7)) return 1'b1;
    sz = acc_size(wr, so, lf);
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input int widx);
    return {ref_b[4*widx+3], ref_b[4*widx+2], ref_b[4*widx+1], ref_b[4*widx]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] lf);
    logic [31:0] v;
    int sz;
    sz = acc_size(1'b0, 2'd0, lf);
    v  = 32'd0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_b[a+i]) << (8*i));
    if (!lf[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
    return v;
  endfunction

  task automatic set_word(input int widx, input logic [31:0] val);
    bus_mem[widx] = val;
    for (int i = 0; i < 4; i++) ref_b[4*widx+i] = 8'(val >> (8*i));
  endtask

  task automatic do_cmd(input bit rd, input bit wr, input logic [1:0] so, input logic [2:0] lf,
                        input logic [31:0] a, input logic [31:0] wd, input int drd, input int dwr,
                        input bit nak, output logic [31:0] got_rdata, output int got_lat);
    bit illegal, seen, sub;
    int erh, ewh, elat, sz;
    logic eerr;
    logic [31:0] erd;
    illegal = is_illegal(rd, wr, so, lf, a);
    sz      = acc_size(wr, so, lf);
    sub     = wr && so != 2'd3;
    erd     = 32'd0;
    if (illegal) begin
      erh = 0; ewh = 0; elat = 1; eerr = 1'b1;
    end else if (nak) begin
      erh = (wr && so == 2'd3) ? 0 : T;
      ewh = (wr && so == 2'd3) ? T : 0;
      elat = 1 + T; eerr = 1'b1;
    end else begin
      erh  = (rd || sub) ? drd + 1 : 0;
      ewh  = wr ? dwr + 1 : 0;
      elat = 1 + erh + ewh + (sub ? 1 : 0);
      eerr = 1'b0;
      if (rd) erd = ref_load(a, lf);
    end
    @(negedge clk);
    chk("ready_before", 32'(req_ready), 32'd1);
    rd_hi = 0; wr_hi = 0; n_rd = 0; n_wr = 0;
    cur_waddr = a[31:2]; d_rd = drd; d_wr = dwr; no_ack = nak;
    req_valid = 1'b1; memread = rd; memwrite = wr; storeops = so;
    load_funct = lf; addr = a; wdata = wd;
    @(posedge clk);
    got_lat = 0; seen = 1'b0;
    while (got_lat < 60 && !seen) begin
      @(negedge clk);
      got_lat++;
      if (resp_valid === 1'b1) seen = 1'b1;
      else begin
        req_valid = 1'($urandom); memread = 1'($urandom); memwrite = 1'($urandom);
        storeops = 2'($urandom); load_funct = 3'($urandom);
        addr = $urandom; wdata = $urandom;
      end
    end
    req_valid = 1'b0;
    got_rdata = rdata;
    chk("resp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(got_lat), 32'(elat));
    chk("err", 32'(err), 32'(eerr));
    chk("rdata", rdata, erd);
    chk("rd_req_cycles", 32'(rd_hi), 32'(erh));
    chk("wr_req_cycles", 32'(wr_hi), 32'(ewh));
    @(posedge clk);
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
    if (!illegal && !nak && wr)
      for (int i = 0; i < sz; i++) ref_b[a+i] = 8'(wd >> (8*i));
    chk("mem_word", bus_mem[a[11:2]], ref_word(int'(a[11:2])));
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    rst = 1'b1; req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
    storeops = 2'd0; load_funct = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0; no_ack = 1'b0; stray_en = 1'b0;
    d_rd = 0; d_wr = 0; phase_cnt = 0; rd_hi = 0; wr_hi = 0; n_rd = 0; n_wr = 0;
    cur_waddr = '0; ph_we = 1'b0; ph_wdata = '0; last_wdata = '0;
    for (int i = 0; i < 4096; i++) ref_b[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) bus_mem[i] = ref_word(i);

    // Memory responder: acks each phase after d_rd/d_wr extra cycles,
    // checks bus stability, and injects stray acks while mem_req is low.
    fork
      forever begin
        @(negedge clk);
        mem_ack = 1'b0;
        if (mem_req === 1'b1) begin
          if (phase_cnt > 0) begin
            chk("hold_we", 32'(mem_we), 32'(ph_we));
            chk("hold_wdata", mem_wdata, ph_wdata);
          end else begin
            ph_we = mem_we; ph_wdata = mem_wdata;
          end
          chk("mem_addr", {2'b00, mem_addr}, {2'b00, cur_waddr});
          if (mem_we) wr_hi++; else rd_hi++;
          if (!no_ack && phase_cnt == (mem_we ? d_wr : d_rd)) begin
            mem_ack = 1'b1;
            if (mem_we) begin
              bus_mem[mem_addr[9:0]] = mem_wdata; last_wdata = mem_wdata; n_wr++;
            end else begin
              mem_rdata = bus_mem[mem_addr[9:0]]; n_rd++;
            end
            phase_cnt = 0;
          end else phase_cnt++;
        end else begin
          phase_cnt = 0;
          if (stray_en && $urandom_range(3) == 0) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
          end
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_maddr", {2'b00, mem_addr}, 32'd0);
    rst = 1'b0;

    // Loads with sign/zero extension
    set_word(32'h40, 32'h80FF_1234);
    do_cmd(1, 0, 2'd0, 3'd0, 32'h103, 32'd0, 0, 0, 0, r, lat);
    chk("lb_value", r, 32'hFFFF_FF80);
    chk("lb_latency", 32'(lat), 32'd2);
    set_word(32'h40, 32'h8001_0000);
    do_cmd(1, 0, 2'd0, 3'd5, 32'h102, 32'd0, 0, 0, 0, r, lat);
    chk("lhu_value", r, 32'h0000_8001);
    do_cmd(1, 0, 2'd0, 3'd1, 32'h102, 32'd0, 1, 0, 0, r, lat);
    chk("lh_value", r, 32'hFFFF_8001);

    // Byte store via read-modify-write
    set_word(32'h80, 32'h1122_3344);
    do_cmd(0, 1, 2'd1, 3'd0, 32'h201, 32'h0000_00AB, 0, 0, 0, r, lat);
    chk("sb_wdata", last_wdata, 32'h1122_AB44);
    chk("sb_latency", 32'(lat), 32'd4);
    chk("sb_reads", 32'(n_rd), 32'd1);

    // Word store with delayed ack
    do_cmd(0, 1, 2'd3, 3'd0, 32'h8, 32'hDEAD_BEEF, 0, 3, 0, r, lat);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("sw_reads", 32'(n_rd), 32'd0);

    // Misaligned and illegal commands
    do_cmd(1, 0, 2'd0, 3'd2, 32'h6, 32'd0, 0, 0, 0, r, lat);
    do_cmd(0, 1, 2'd2, 3'd0, 32'h5, 32'h1234, 0, 0, 0, r, lat);
    do_cmd(1, 1, 2'd3, 3'd2, 32'h10, 32'h1234, 0, 0, 0, r, lat);

    // Half store timing out in the read phase: no write issued
    do_cmd(0, 1, 2'd2, 3'd0, 32'h44, 32'hBEEF, 0, 0, 1, r, lat);
    chk("to_writes", 32'(n_wr), 32'd0);

    // Reset while a write is in flight
    @(negedge clk);
    cur_waddr = 30'h4; no_ack = 1'b1;
    req_valid = 1'b1; memread = 1'b0; memwrite = 1'b1; storeops = 2'd3;
    load_funct = 3'd0; addr = 32'h10; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midwr_req", 32'(mem_req & mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midwr_rst_req", 32'(mem_req), 32'd0);
    chk("midwr_rst_ready", 32'(req_ready), 32'd1);
    chk("midwr_rst_resp", 32'(resp_valid), 32'd0);
    rst = 1'b0; no_ack = 1'b0;
    @(negedge clk);
    chk("midwr_no_resp", 32'(resp_valid), 32'd0);
    chk("midwr_mem", bus_mem[4], ref_word(4));

    // Command with neither memread nor memwrite is ignored
    req_valid = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = 32'h20;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ignored_ready", 32'(req_ready), 32'd1);
    chk("ignored_req", 32'(mem_req), 32'd0);
    chk("ignored_resp", 32'(resp_valid), 32'd0);

    // Random commands with stray acks
    stray_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      bit rd, wr, nak;
      logic [1:0] so;
      logic [2:0] lf;
      logic [31:0] a;
      int kind, sz, drd, dwr;
      kind = $urandom_range(19);
      rd = (kind < 9) || (kind >= 18);
      wr = (kind >= 9);
      if ($urandom_range(9) == 0) lf = 3'($urandom);
      else begin
        case ($urandom_range(4))
          0: lf = 3'd0;
          1: lf = 3'd1;
          2: lf = 3'd2;
          3: lf = 3'd4;
          default: lf = 3'd5;
        endcase
      end
      so = ($urandom_range(9) == 0) ? 2'd0 : 2'($urandom_range(3, 1));
      a  = 32'($urandom_range(4095));
      sz = acc_size(wr, so, lf);
      if ($urandom_range(4) != 0) a = a & ~32'(sz - 1);
      drd = $urandom_range(T - 1);
      dwr = $urandom_range(T - 1);
      nak = ($urandom_range(11) == 0);
      do_cmd(rd, wr, so, lf, a, $urandom, drd, dwr, nak, r, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
